// File: rtl/reg_bank_streamer.sv
// reg_bank_streamer: snapshots a packed register bank on start and streams it out
// one word per valid/ready beat, reporting a wrap-around checksum with a done pulse.
module reg_bank_streamer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]              out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_last_o,
    output logic [IDXW-1:0]               out_index_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [WIDTH-1:0]              checksum_o
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0] snap_q;
    logic [IDXW-1:0] idx_q;
    logic [WIDTH-1:0] acc_q, csum_q, sum;
    logic xfer, at_last;
    assign at_last     = idx_q == IDXW'(DEPTH - 1);
    assign xfer        = state_q == STREAM && out_ready_i;
    assign sum         = acc_q + out_data_o;
    assign out_valid_o = state_q == STREAM;
    assign out_data_o  = snap_q[idx_q];
    assign out_index_o = idx_q;
    assign out_last_o  = out_valid_o && at_last;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign checksum_o  = csum_q;
    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE   ? (start_i ? STREAM : IDLE) :
                  state_q == STREAM ? (xfer && at_last ? DONE : STREAM) : IDLE;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end
    // The index parks on the last entry through DONE; only valid qualifies it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_q <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            csum_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            snap_q <= data_i;
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (xfer) begin
            acc_q <= sum;
            if (at_last) csum_q <= sum;
            else idx_q <= idx_q + IDXW'(1);
        end
    end
endmodule

// File: tb/tb_reg_bank_streamer.sv
// tb_reg_bank_streamer: randomized scoreboard bench; the stimulus side pushes the
// expected beats and checksum of each run, a negedge monitor pops and compares them.
module tb_reg_bank_streamer;
    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int IDXW  = 5;
    typedef logic [DEPTH-1:0][WIDTH-1:0] bank_t;
    typedef struct {
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;
    logic clk_i = 0, rst_i = 1, start_i = 0, out_ready_i = 0;
    bank_t data_i = '0;
    logic [WIDTH-1:0] out_data_o, checksum_o;
    logic out_valid_o, out_last_o, busy_o, done_o;
    logic [IDXW-1:0] out_index_o;
    beat_t beat_q[$];
    logic [WIDTH-1:0] csum_q[$];
    logic [WIDTH-1:0] held = '0;
    int checks = 0, failures = 0;
    int rmode = 0, rcnt = 0;
    logic prev_stall = 0;
    logic [WIDTH-1:0] p_data;
    logic [IDXW-1:0] p_idx;
    logic p_last;

    reg_bank_streamer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .data_i(data_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .out_index_o(out_index_o), .busy_o(busy_o),
        .done_o(done_o), .checksum_o(checksum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: a run is the bank as seen at the capture edge, in index order.
    task automatic push_run(input bank_t d);
        logic [WIDTH-1:0] s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            beat_q.push_back('{idx: IDXW'(k), data: d[k], last: k == DEPTH - 1});
            s += d[k];
        end
        csum_q.push_back(s);
    endtask

    // Ready generator: 0 = always ready, 1 = alternating with a 5-cycle gap, 2 = random.
    initial forever begin
        @(posedge clk_i);
        #1;
        rcnt++;
        out_ready_i = rmode == 0 ? 1'b1 :
                      rmode == 1 ? ((rcnt >= 10 && rcnt < 15) ? 1'b0 : rcnt[0]) :
                      ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk_i) begin
        beat_t b;
        logic [WIDTH-1:0] e;
        if (rst_i) prev_stall = 0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", out_data_o, p_data);
                chk("stall_index", out_index_o, p_idx);
                chk("stall_last", out_last_o, p_last);
            end
            if (out_valid_o && out_ready_i) begin
                if (beat_q.size() == 0) fail("unexpected_beat");
                else begin
                    b = beat_q.pop_front();
                    chk("beat_index", out_index_o, b.idx);
                    chk("beat_data", out_data_o, b.data);
                    chk("beat_last", out_last_o, b.last);
                end
            end
            if (done_o) begin
                chk("done_valid", out_valid_o, 0);
                chk("done_busy", busy_o, 1);
                if (csum_q.size() == 0) fail("unexpected_done");
                else begin
                    e = csum_q.pop_front();
                    chk("checksum", checksum_o, e);
                    held = e;
                end
            end else chk("checksum_hold", checksum_o, held);
            prev_stall = out_valid_o && !out_ready_i;
            p_data = out_data_o;
            p_idx = out_index_o;
            p_last = out_last_o;
        end
    end

    task automatic start_run(input bank_t d);
        @(posedge clk_i);
        #1;
        data_i = d;
        start_i = 1;
        push_run(d);
        @(posedge clk_i);
        #1;
        start_i = 0;
        chk("start_valid", out_valid_o, 1);
        chk("start_busy", busy_o, 1);
        chk("start_index", out_index_o, 0);
    endtask

    task automatic wait_done();
        logic seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk_i);
            seen = done_o;
        end
        if (!seen) fail("done_timeout");
    endtask

    task automatic wait_idx(input int i);
        logic seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk_i);
            seen = out_valid_o && out_index_o == IDXW'(i);
        end
        if (!seen) fail("index_timeout");
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, out_valid_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_done"}, done_o, 0);
        chk({name, "_last"}, out_last_o, 0);
        chk({name, "_index"}, out_index_o, 0);
        chk({name, "_data"}, out_data_o, 0);
        chk({name, "_checksum"}, checksum_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1;
        beat_q.delete();
        csum_q.delete();
        held = '0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 0;
    endtask

    function automatic bank_t ramp();
        bank_t d;
        for (int k = 0; k < DEPTH; k++) d[k] = WIDTH'(32'h1000 + k);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bank_t d;
        #1;
        check_zero("por");
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("idle_valid", out_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        // Full back-to-back run
        rmode = 0;
        start_run(ramp());
        repeat (DEPTH) @(posedge clk_i);
        #1;
        chk("b2b_done", done_o, 1);
        chk("b2b_checksum", checksum_o, 32'h000201F0);
        @(posedge clk_i);
        #2;
        do_reset();
        // Backpressure
        rmode = 1;
        rcnt = 0;
        start_run(ramp());
        wait_done();
        chk("bp_checksum", checksum_o, 32'h000201F0);
        // Snapshot isolation and wrap
        rmode = 2;
        start_run('1);
        wait_idx(3);
        #1;
        data_i = '0;
        wait_done();
        chk("wrap_checksum", checksum_o, 32'hFFFFFFE0);
        start_run('0);
        chk("start_keeps_checksum", checksum_o, 32'hFFFFFFE0);
        wait_done();
        chk("zero_checksum", checksum_o, 0);
        // Start while busy, then restart in the first IDLE cycle
        rmode = 0;
        start_run(ramp());
        wait_idx(5);
        #1;
        start_i = 1;
        @(posedge clk_i);
        #1;
        start_i = 0;
        wait_idx(31);
        #1;
        start_i = 1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        push_run(data_i);
        @(negedge clk_i);
        chk("done_start_ignored_busy", busy_o, 0);
        chk("done_start_ignored_valid", out_valid_o, 0);
        @(posedge clk_i);
        #1;
        start_i = 0;
        chk("restart_valid", out_valid_o, 1);
        chk("restart_index", out_index_o, 0);
        wait_done();
        // Reset mid-stream
        rmode = 2;
        start_run(ramp());
        rmode = 0;
        wait_idx(10);
        #1;
        do_reset();
        repeat (3) @(negedge clk_i);
        chk("abort_done", done_o, 0);
        chk("abort_checksum", checksum_o, 0);
        start_run(ramp());
        wait_done();
        chk("post_abort_checksum", checksum_o, 32'h000201F0);
        // Random runs
        for (int r = 0; r < 4; r++) begin
            rmode = 2;
            for (int k = 0; k < DEPTH; k++) d[k] = $urandom;
            start_run(d);
            wait_idx(int'($urandom_range(1, DEPTH - 1)));
            #1;
            for (int k = 0; k < DEPTH; k++) data_i[k] = $urandom;
            wait_done();
        end
        repeat (5) @(posedge clk_i);
        chk("beats_left", beat_q.size(), 0);
        chk("runs_left", csum_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank_streamer.md
Name: reg_bank_streamer

Overview:
Downstream consumer of the 32-entry register bank. On a start pulse it captures a snapshot of the whole packed bank, then streams the entries out one word per beat over a valid/ready handshake. It produces a wrap-around 32-bit sum of all streamed words and pulses done when the last beat has been accepted. It sits between the register bank and any serial sink, such as a UART/debug port or a checker.

Parameters:
DEPTH, 32, number of bank entries streamed per run (must be ≥2)
WIDTH, 32, bits per entry and width of the checksum
IDXW, $clog2(DEPTH), width of out_index_o

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  reset; asynchronous, active-high
start_i  input  1  request a snapshot+stream run; sampled only in IDLE
data_i  input  [DEPTH-1:0][WIDTH-1:0]  packed bank contents; entry k = data_i[k]
out_data_o  output  WIDTH  current beat word
out_valid_o  output  1  beat valid
out_ready_i  input  1  sink accepts beat
out_last_o  output  1  high with valid on final beat (index DEPTH-1)
out_index_o  output  IDXW  bank index of current beat
busy_o  output  1  run in progress (STREAM or DONE)
done_o  output  1  one-cycle pulse after final beat accepted
checksum_o  output  WIDTH  sum of last completed run, mod 2^WIDTH

Behaviour:
- Reset (async assert, any state) has immediate effect:
  - state=IDLE; all outputs 0, including checksum_o.
  - Snapshot registers, index and accumulator are cleared.
  - Release is synchronous to clk_i.
- FSM states: IDLE, STREAM, DONE.
- IDLE, start_i=1 at an edge:
  - snapshot<=data_i (all DEPTH entries); index<=0; acc<=0; go to STREAM.
  - out_valid_o and busy_o go high in the next cycle (1-cycle latency from start).
- STREAM:
  - out_valid_o=1; out_data_o=snapshot[index]; out_index_o=index; out_last_o=(index==DEPTH-1).
  - All beat outputs are driven from registers only. There is no combinational path from data_i or out_ready_i to any output.
  - A transfer occurs at an edge with valid&&ready:
    - acc<=acc+out_data_o, truncated to WIDTH bits (wrap, no saturation).
    - If index==DEPTH-1: go to DONE. Otherwise index<=index+1.
  - Stall (valid&&!ready): out_data_o, out_index_o and out_last_o are held stable. valid is never withdrawn before transfer.
  - Back-to-back transfers are allowed: with ready held high, one beat per cycle, DEPTH beats in DEPTH consecutive cycles.
- DONE (exactly one cycle):
  - out_valid_o=0; done_o=1; busy_o=1.
  - checksum_o=final acc (registered on the last-transfer edge, so it is valid in the same cycle as done_o).
  - Next state is IDLE.
- checksum_o holds its value until the next run's DONE or a reset. It is not cleared by start_i.
- start_i is ignored in STREAM and DONE (no queuing). The earliest restart is start_i sampled in the first IDLE cycle after DONE.
- Snapshot isolation: changes on data_i after the capture edge never affect the current run.
- out_ready_i is ignored when out_valid_o=0.
- Reset mid-stream aborts the run: out_valid_o drops asynchronously, done_o never pulses, and checksum_o reads 0.

Test Plan:
1. Reset check: hold rst_i=1 mid-simulation → all outputs 0 immediately, without waiting for a clock edge. Release, then idle 5 cycles → out_valid_o=0, busy_o=0.
2. Full run, out_ready_i=1, data_i[k]=32'h1000+k, pulse start_i:
   - valid rises the next cycle; 32 consecutive beats with index 0..31, data 0x1000..0x101F.
   - out_last_o only on beat 31.
   - done_o high in the following cycle with checksum_o=32'h000201F0.
3. Backpressure: same data, out_ready_i alternating 1/0 (plus one 5-cycle low stretch) → data, index and last stable during stalls; exactly 32 transfers, none dropped or duplicated; checksum_o=32'h000201F0.
4. Snapshot isolation + wrap:
   - Start with all entries 32'hFFFFFFFF, then set data_i to all 0 at beat 3 → every beat still reads FFFFFFFF; checksum_o=32'hFFFFFFE0.
   - A second run now streams zeros → checksum_o=0.
5. Start while busy: pulse start_i at beats 5 and 31 and in the DONE cycle → run unaffected. A start_i in the first IDLE cycle begins a new run at index 0.
6. Reset mid-stream: assert rst_i at beat 10 → valid low immediately; no done_o; checksum_o=0. After release a new start streams from index 0 with the correct checksum.
